// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and a
// helper for sizing the bit counter.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

    // Ceiling log2, never less than 1 so the counter always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full adder cell used as the bit-slice of the serial subtractor.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of three one-bit inputs.
    always_comb begin
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock by feeding a and
// inverted b through one full adder, carry seeded with 1. Results appear
// WIDTH cycles after an accepted start and hold until the next completion.
//
// Handshake: start is sampled only while busy=0; the sampling edge captures
// a and b, and busy rises. busy stays high for WIDTH cycles; at the final
// edge busy falls and done pulses for exactly one cycle with diff, borrow
// and overflow updated. start while busy is ignored. start high in the done
// cycle is accepted because the block is already idle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] r_next;

    // The one bit-slice: a - b = a + ~b + 1 evaluated LSB first.
    full_adder u_fa (
        .x  (a_sr_q[0]),
        .y  (~b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Result register after this edge's bit lands in the MSB.
    always_comb begin
        r_next = {fa_s, r_sr_q[WIDTH-1:1]};
    end

    // Next-state and datapath control for IDLE/RUN.
    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        r_sr_d     = r_sr_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    r_sr_d  = '0;
                    c_d     = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = r_next;
                c_d    = fa_co;
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish results; counter parks at zero.
                    cnt_d      = '0;
                    diff_d     = r_next;
                    borrow_d   = ~fa_co;
                    overflow_d = (a_msb_q != b_msb_q) && (fa_s != a_msb_q);
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, shift registers and result registers; reset aborts everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            r_sr_q     <= '0;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            r_sr_q     <= r_sr_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=4 and WIDTH=8: directed vectors with
// hand-computed results, handshake timing, ignored start, back-to-back,
// mid-operation reset, plus a short sweep against an arithmetic model.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic       start4, busy4, done4, borrow4, ovf4;
    logic [3:0] a4, b4, diff4;
    logic       start8, busy8, done8, borrow8, ovf8;
    logic [7:0] a8, b8, diff8;

    int total;
    int bad;
    int sel_w;
    int accepted4, accepted8;
    int dones4, dones8;

    // {overflow, borrow, diff} expected for each accepted operation
    logic [33:0] exp_q[$];

    logic        obs_done, obs_busy, obs_borrow, obs_ovf;
    logic [31:0] obs_diff;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(ovf4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses; each lasts one cycle so one negedge sample per pulse.
    always @(negedge clk) begin
        if (done4) dones4 = dones4 + 1;
        if (done8) dones8 = dones8 + 1;
    end

    always_comb begin
        if (sel_w == 4) begin
            obs_done = done4; obs_busy = busy4; obs_borrow = borrow4; obs_ovf = ovf4;
            obs_diff = {28'd0, diff4};
        end else begin
            obs_done = done8; obs_busy = busy8; obs_borrow = borrow8; obs_ovf = ovf8;
            obs_diff = {24'd0, diff8};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
        if (w == 4) begin
            start4 = s; a4 = av[3:0]; b4 = bv[3:0];
        end else begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    task automatic push_exp(input int w, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] mask, d;
        logic am, bm, brw, ovf;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        d    = (av - bv) & mask;
        am   = av[w-1];
        bm   = bv[w-1];
        brw  = ((av & mask) < (bv & mask));
        ovf  = (am != bm) && (d[w-1] != am);
        exp_q.push_back({ovf, brw, d});
        if (w == 4) accepted4 = accepted4 + 1; else accepted8 = accepted8 + 1;
    endtask

    // Waits for done, counting edges since the accepting edge (already n0).
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!obs_done && n < 40) begin
            @(posedge clk); #1;
            n = n + 1;
        end
    endtask

    task automatic check_result(input string tag);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_diff"}, obs_diff, e[31:0]);
            check({tag, "_borrow"}, {31'd0, obs_borrow}, {31'd0, e[32]});
            check({tag, "_ovf"}, {31'd0, obs_ovf}, {31'd0, e[33]});
        end
    endtask

    // Full operation: start, latency, busy, results, one-cycle done.
    task automatic run_op(input string tag, input int w, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ed,
                          input logic eb, input logic eo);
        int n;
        sel_w = w;
        @(posedge clk); #1;
        drive(w, 1'b1, av, bv);
        push_exp(w, av, bv);
        @(posedge clk); #1;
        drive(w, 1'b0, $urandom, $urandom);
        check({tag, "_busy"}, {31'd0, obs_busy}, 32'd1);
        wait_done(0, n);
        check({tag, "_latency"}, n, w);
        check({tag, "_busy_at_done"}, {31'd0, obs_busy}, 32'd0);
        check({tag, "_hand_diff"}, obs_diff, ed);
        check({tag, "_hand_borrow"}, {31'd0, obs_borrow}, {31'd0, eb});
        check({tag, "_hand_ovf"}, {31'd0, obs_ovf}, {31'd0, eo});
        check_result(tag);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, {31'd0, obs_done}, 32'd0);
        check({tag, "_hold_diff"}, obs_diff, ed);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] ra, rb;
        total = 0; bad = 0; sel_w = 4;
        accepted4 = 0; accepted8 = 0; dones4 = 0; dones8 = 0;
        rst_n = 1'b0;
        drive(4, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_done4", {31'd0, done4}, 32'd0);
        check("rst_diff4", {28'd0, diff4}, 32'd0);
        check("rst_borrow4", {31'd0, borrow4}, 32'd0);
        check("rst_ovf4", {31'd0, ovf4}, 32'd0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_diff8", {24'd0, diff8}, 32'd0);
        rst_n = 1'b1;

        // Directed WIDTH=4 vectors
        run_op("w4_7m2", 4, 7, 2, 32'h5, 1'b0, 1'b0);
        run_op("w4_3m5", 4, 3, 5, 32'hE, 1'b1, 1'b0);
        run_op("w4_8m1", 4, 8, 1, 32'h7, 1'b0, 1'b1);
        run_op("w4_0m0", 4, 0, 0, 32'h0, 1'b0, 1'b0);

        // Ignored start mid-run, then back-to-back start in the done cycle
        sel_w = 4;
        @(posedge clk); #1;
        drive(4, 1'b1, 6, 1);
        push_exp(4, 6, 1);
        @(posedge clk); #1;
        drive(4, 1'b0, 0, 0);
        @(posedge clk); #1;
        drive(4, 1'b1, 0, 9);
        @(posedge clk); #1;
        drive(4, 1'b0, 0, 0);
        check("ign_busy", {31'd0, busy4}, 32'd1);
        wait_done(2, n);
        check("ign_latency", n, 4);
        check("ign_diff", {28'd0, diff4}, 32'h5);
        check_result("ign");
        drive(4, 1'b1, 4, 4);
        push_exp(4, 4, 4);
        @(posedge clk); #1;
        drive(4, 1'b0, 15, 3);
        check("b2b_busy", {31'd0, busy4}, 32'd1);
        check("b2b_done_low", {31'd0, done4}, 32'd0);
        check("b2b_hold_diff", {28'd0, diff4}, 32'h5);
        wait_done(0, n);
        check("b2b_latency", n, 4);
        check("b2b_diff", {28'd0, diff4}, 32'h0);
        check_result("b2b");
        @(posedge clk); #1;

        // Reset mid-operation (previous result nonzero first)
        run_op("w4_9m2", 4, 9, 2, 32'h7, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(4, 1'b1, 5, 3);
        @(posedge clk); #1;
        drive(4, 1'b0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy4}, 32'd0);
        check("midrst_diff", {28'd0, diff4}, 32'd0);
        check("midrst_ovf", {31'd0, ovf4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_done", dones4, accepted4);
        run_op("w4_after_rst", 4, 2, 7, 32'hB, 1'b1, 1'b0);

        // Directed WIDTH=8 vectors
        run_op("w8_00m01", 8, 32'h00, 32'h01, 32'hFF, 1'b1, 1'b0);
        run_op("w8_80m01", 8, 32'h80, 32'h01, 32'h7F, 1'b0, 1'b1);
        run_op("w8_7Fm80", 8, 32'h7F, 32'h80, 32'hFF, 1'b1, 1'b1);

        // Sweep against the arithmetic model
        for (int i = 0; i < 100; i++) begin
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            sel_w = 4;
            @(posedge clk); #1;
            drive(4, 1'b1, ra, rb);
            push_exp(4, ra, rb);
            @(posedge clk); #1;
            drive(4, 1'b0, 0, 0);
            wait_done(0, n);
            check("rnd4_latency", n, 4);
            check_result("rnd4");
        end
        for (int i = 0; i < 100; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            sel_w = 8;
            @(posedge clk); #1;
            drive(8, 1'b1, ra, rb);
            push_exp(8, ra, rb);
            @(posedge clk); #1;
            drive(8, 1'b0, 0, 0);
            wait_done(0, n);
            check("rnd8_latency", n, 8);
            check_result("rnd8");
        end

        repeat (3) @(posedge clk);
        #1;
        check("done_count4", dones4, accepted4);
        check("done_count8", dones8, accepted8);
        check("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
